// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults) and the per-axis region encoding.
package vga_timing_pkg;

  localparam int unsigned CountW = 10;

  localparam int unsigned TotalCols   = 800;
  localparam int unsigned ActiveCols  = 640;
  localparam int unsigned HFrontPorch = 16;
  localparam int unsigned HSyncWidth  = 96;

  localparam int unsigned TotalRows   = 525;
  localparam int unsigned ActiveRows  = 480;
  localparam int unsigned VFrontPorch = 10;
  localparam int unsigned VSyncWidth  = 2;

  typedef enum logic [1:0] {
    RegActive = 2'd0,
    RegFront  = 2'd1,
    RegSync   = 2'd2,
    RegBack   = 2'd3
  } region_e;

endpackage

// File: rtl/vga_axis_timer.sv
// One timing axis: a wrapping position counter plus a region FSM (active/front/sync/back).
// wrap_o is combinational so the next axis can advance on the same edge.
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL  = 800,
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FRONT  = 16,
  parameter int unsigned SYNC   = 96
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              advance_i,
  output logic [CountW-1:0] count_o,
  output logic [1:0]        region_next_o,
  output logic              wrap_o
);

  if (ACTIVE == 0 || FRONT == 0 || SYNC == 0 || ACTIVE + FRONT + SYNC >= TOTAL ||
      TOTAL > 1024) begin : g_bad_params
    $error("vga_axis_timer: illegal timing parameters");
  end

  localparam logic [CountW-1:0] Last       = CountW'(TOTAL - 1);
  localparam logic [CountW-1:0] FrontStart = CountW'(ACTIVE);
  localparam logic [CountW-1:0] SyncStart  = CountW'(ACTIVE + FRONT);
  localparam logic [CountW-1:0] BackStart  = CountW'(ACTIVE + FRONT + SYNC);

  logic [CountW-1:0] count_q, count_d;
  region_e           region_q, region_d;
  logic              wrap;

  assign wrap = advance_i && (count_q == Last);

  always_comb begin
    count_d  = count_q;
    region_d = region_q;
    if (advance_i) begin
      count_d = wrap ? '0 : count_q + CountW'(1);
      // Region changes on the edge whose next count lands on a boundary.
      unique case (region_q)
        RegActive: if (count_d == FrontStart) region_d = RegFront;
        RegFront:  if (count_d == SyncStart)  region_d = RegSync;
        RegSync:   if (count_d == BackStart)  region_d = RegBack;
        RegBack:   if (wrap)                  region_d = RegActive;
        default:                              region_d = RegBack;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q  <= Last;
      region_q <= RegBack;
    end else begin
      count_q  <= count_d;
      region_q <= region_d;
    end
  end

  assign count_o       = count_q;
  assign region_next_o = region_d;
  assign wrap_o        = wrap;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync/timing source: two axis timers plus registered sync, active, strobe and
// frame-count outputs, all aligned with the column/row counts they describe.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL_COLS    = TotalCols,
  parameter int unsigned TOTAL_ROWS    = TotalRows,
  parameter int unsigned ACTIVE_COLS   = ActiveCols,
  parameter int unsigned ACTIVE_ROWS   = ActiveRows,
  parameter int unsigned H_FRONT_PORCH = HFrontPorch,
  parameter int unsigned H_SYNC_WIDTH  = HSyncWidth,
  parameter int unsigned V_FRONT_PORCH = VFrontPorch,
  parameter int unsigned V_SYNC_WIDTH  = VSyncWidth
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Pix_En,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Active,
  output logic       o_Line_Start,
  output logic       o_Frame_Start,
  output logic [7:0] o_Frame_Count
);

  logic [1:0] h_region_next, v_region_next;
  logic       h_wrap, v_wrap;

  vga_axis_timer #(
    .TOTAL  (TOTAL_COLS),
    .ACTIVE (ACTIVE_COLS),
    .FRONT  (H_FRONT_PORCH),
    .SYNC   (H_SYNC_WIDTH)
  ) u_h_timer (
    .clk_i         (i_Clk),
    .rst_ni        (i_Rst_L),
    .advance_i     (i_Pix_En),
    .count_o       (o_Col_Count),
    .region_next_o (h_region_next),
    .wrap_o        (h_wrap)
  );

  // Rows step only when the column counter wraps.
  vga_axis_timer #(
    .TOTAL  (TOTAL_ROWS),
    .ACTIVE (ACTIVE_ROWS),
    .FRONT  (V_FRONT_PORCH),
    .SYNC   (V_SYNC_WIDTH)
  ) u_v_timer (
    .clk_i         (i_Clk),
    .rst_ni        (i_Rst_L),
    .advance_i     (h_wrap),
    .count_o       (o_Row_Count),
    .region_next_o (v_region_next),
    .wrap_o        (v_wrap)
  );

  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       active_q, active_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;

  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    frame_count_d = frame_count_q;
    // h_wrap already carries i_Pix_En, so strobes drop to 0 on disabled cycles.
    line_start_d  = h_wrap;
    frame_start_d = h_wrap && v_wrap;
    if (i_Pix_En) begin
      hsync_d  = (h_region_next != RegSync);
      vsync_d  = (v_region_next != RegSync);
      active_d = (h_region_next == RegActive) && (v_region_next == RegActive);
    end
    if (frame_start_d) begin
      frame_count_d = frame_count_q + 8'd1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign o_HSync       = hsync_q;
  assign o_VSync       = vsync_q;
  assign o_Active      = active_q;
  assign o_Line_Start  = line_start_q;
  assign o_Frame_Start = frame_start_q;
  assign o_Frame_Count = frame_count_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a shrunken 16x10 raster so full frames and the 256-frame
// frame-count wrap stay short; outputs are predicted from the enabled-edge count.
module tb_vga_sync_gen;

  localparam int TC = 16;
  localparam int TR = 10;
  localparam int AC = 8;
  localparam int AR = 5;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int FRAME = TC * TR;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_Pix_En = 1'b0;
  logic       o_HSync, o_VSync, o_Active, o_Line_Start, o_Frame_Start;
  logic [9:0] o_Col_Count, o_Row_Count;
  logic [7:0] o_Frame_Count;

  vga_sync_gen #(
    .TOTAL_COLS    (TC),
    .TOTAL_ROWS    (TR),
    .ACTIVE_COLS   (AC),
    .ACTIVE_ROWS   (AR),
    .H_FRONT_PORCH (HF),
    .H_SYNC_WIDTH  (HS),
    .V_FRONT_PORCH (VF),
    .V_SYNC_WIDTH  (VS)
  ) dut (
    .i_Clk         (i_Clk),
    .i_Rst_L       (i_Rst_L),
    .i_Pix_En      (i_Pix_En),
    .o_HSync       (o_HSync),
    .o_VSync       (o_VSync),
    .o_Col_Count   (o_Col_Count),
    .o_Row_Count   (o_Row_Count),
    .o_Active      (o_Active),
    .o_Line_Start  (o_Line_Start),
    .o_Frame_Start (o_Frame_Start),
    .o_Frame_Count (o_Frame_Count)
  );

  always #5 i_Clk = ~i_Clk;

  int     checks = 0;
  int     failures = 0;
  longint n = 0;         // enabled edges since the last reset edge
  bit     en_edge = 1'b0;
  int     hs_low, vs_low, ls_cnt, fs_cnt, strobe_bad, gap_bad, en_cnt;
  longint last_fs;

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Position is simply (n-1) pixels into the raster; n==0 means the reset pixel.
  task automatic model_compare();
    longint p;
    int col, row, fc;
    bit hs, vs, act, ls, fs;
    if (n == 0) begin
      col = TC - 1;
      row = TR - 1;
      fc  = 0;
    end else begin
      p   = n - 1;
      col = int'(p % TC);
      row = int'((p / TC) % TR);
      fc  = int'((p / FRAME + 1) % 256);
    end
    hs  = !(col >= AC + HF && col < AC + HF + HS);
    vs  = !(row >= AR + VF && row < AR + VF + VS);
    act = (n != 0) && col < AC && row < AR;
    ls  = en_edge && (n != 0) && col == 0;
    fs  = ls && row == 0;
    check("col", longint'(o_Col_Count), longint'(col));
    check("row", longint'(o_Row_Count), longint'(row));
    check("hsync", longint'(o_HSync), longint'(hs));
    check("vsync", longint'(o_VSync), longint'(vs));
    check("active", longint'(o_Active), longint'(act));
    check("line_start", longint'(o_Line_Start), longint'(ls));
    check("frame_start", longint'(o_Frame_Start), longint'(fs));
    check("frame_count", longint'(o_Frame_Count), longint'(fc));
  endtask

  task automatic clear_tallies();
    hs_low = 0; vs_low = 0; ls_cnt = 0; fs_cnt = 0;
    strobe_bad = 0; gap_bad = 0; en_cnt = 0; last_fs = 0;
  endtask

  task automatic step(input bit en, input bit rst_l);
    i_Pix_En = en;
    i_Rst_L  = rst_l;
    @(posedge i_Clk);
    if (!rst_l) begin
      n = 0;
      en_edge = 1'b0;
    end else begin
      en_edge = en;
      if (en) n++;
    end
    @(negedge i_Clk);
    model_compare();
    if (en_edge) begin
      en_cnt++;
      if (!o_HSync) hs_low++;
      if (!o_VSync) vs_low++;
      if (o_Line_Start) ls_cnt++;
      if (o_Frame_Start) begin
        fs_cnt++;
        if (en_cnt - last_fs != FRAME) gap_bad++;
        last_fs = en_cnt;
      end
    end else if (o_Line_Start || o_Frame_Start) begin
      strobe_bad++;
    end
  endtask

  task automatic check_first_edge(input string tag);
    check({tag, "_col"}, longint'(o_Col_Count), 0);
    check({tag, "_row"}, longint'(o_Row_Count), 0);
    check({tag, "_frame_start"}, longint'(o_Frame_Start), 1);
    check({tag, "_line_start"}, longint'(o_Line_Start), 1);
    check({tag, "_active"}, longint'(o_Active), 1);
    check({tag, "_frame_count"}, longint'(o_Frame_Count), 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_col"}, longint'(o_Col_Count), TC - 1);
    check({tag, "_row"}, longint'(o_Row_Count), TR - 1);
    check({tag, "_hsync"}, longint'(o_HSync), 1);
    check({tag, "_vsync"}, longint'(o_VSync), 1);
    check({tag, "_active"}, longint'(o_Active), 0);
    check({tag, "_frame_start"}, longint'(o_Frame_Start), 0);
    check({tag, "_frame_count"}, longint'(o_Frame_Count), 0);
  endtask

  initial begin
    int it;
    clear_tallies();

    // Reset held with random enable; outputs must sit at the last blanking pixel.
    repeat (3) step(1'($urandom_range(0, 1)), 1'b0);
    check_reset_state("rst");

    step(1'b1, 1'b1);
    check_first_edge("first");

    // One full frame at full rate, ending on the next frame start.
    clear_tallies();
    repeat (FRAME) step(1'b1, 1'b1);
    check("full_hsync_low", hs_low, 10 * HS);
    check("full_vsync_low", vs_low, VS * TC);
    check("full_line_starts", ls_cnt, TR);
    check("full_frame_starts", fs_cnt, 1);
    check("full_frame_gap_errs", gap_bad, 0);

    // Two frames' worth of enabled cycles with a random ~50% enable.
    clear_tallies();
    it = 0;
    while (en_cnt < 2 * FRAME && it < 20000) begin
      step(1'($urandom_range(0, 1)), 1'b1);
      it++;
    end
    check("rand_enabled_cycles", en_cnt, 2 * FRAME);
    check("rand_hsync_low", hs_low, 2 * 10 * HS);
    check("rand_vsync_low", vs_low, 2 * VS * TC);
    check("rand_line_starts", ls_cnt, 2 * TR);
    check("rand_frame_starts", fs_cnt, 2);
    check("rand_strobe_while_disabled", strobe_bad, 0);
    check("rand_frame_gap_errs", gap_bad, 0);

    // Frame count is 4 here; run to 255 then wrap to 0.
    repeat (252 * FRAME - 1) step(1'b1, 1'b1);
    check("fc_before_wrap", longint'(o_Frame_Count), 255);
    step(1'b1, 1'b1);
    check("fc_wrap", longint'(o_Frame_Count), 0);
    check("fc_wrap_frame_start", longint'(o_Frame_Start), 1);

    // Mid-frame reset while both syncs are low, with enable low.
    repeat (7 * TC + 12) step(1'b1, 1'b1);
    check("mid_col", longint'(o_Col_Count), 12);
    check("mid_row", longint'(o_Row_Count), 7);
    check("mid_hsync", longint'(o_HSync), 0);
    check("mid_vsync", longint'(o_VSync), 0);
    step(1'b0, 1'b0);
    check_reset_state("midrst");
    step(1'b1, 1'b1);
    check_first_edge("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
